// File: rtl/axi4s_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axi4s_rr_arbiter
// Round-robin packet arbiter merging C_NUM_SRC AXI4-Stream sources onto one
// master stream. A grant is held from the first beat to the tlast beat, so
// packets never interleave. src_enable is only looked at while choosing the
// next source, so disabling a source never cuts a packet that is in flight.
//
// Optional feature macro: AXI4S_ARB_OUTREG_EN
//   undefined : the master stream is a combinational mux of the granted source,
//               forced to zero outside a transfer.
//   defined   : the master stream comes from a two-entry skid buffer. The FSM
//               leaves XFER when the tlast beat enters the buffer, and the
//               buffer may drain while the next arbitration is in progress.
// ----------------------------------------------------------------------------
module axi4s_rr_arbiter #(
    parameter int C_NUM_SRC          = 4,
    parameter int C_AXIS_TDATA_WIDTH = 64
) (
    input  logic                                   m00_axis_aclk,
    input  logic                                   m00_axis_aresetn,
    input  logic [C_NUM_SRC-1:0]                   s_axis_tvalid,
    input  logic [C_NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_NUM_SRC*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_SRC-1:0]                   s_axis_tlast,
    output logic [C_NUM_SRC-1:0]                   s_axis_tready,
    input  logic [C_NUM_SRC-1:0]                   src_enable,
    output logic                                   m00_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]          m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]        m00_axis_tstrb,
    output logic                                   m00_axis_tlast,
    input  logic                                   m00_axis_tready,
    output logic [$clog2(C_NUM_SRC)-1:0]           grant_id,
    output logic                                   busy
);

    localparam int N  = C_NUM_SRC;
    localparam int W  = C_AXIS_TDATA_WIDTH;
    localparam int SW = C_AXIS_TDATA_WIDTH / 8;
    localparam int GW = $clog2(C_NUM_SRC);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]    state_r;
    logic [GW-1:0] grant_r;
    logic [GW-1:0] last_grant_r;

    logic [N-1:0]  cand_s;
    logic          any_cand_s;
    logic [GW-1:0] pick_s;

    logic          sel_valid_s;
    logic [W-1:0]  sel_data_s;
    logic [SW-1:0] sel_strb_s;
    logic          sel_last_s;
    logic          sink_ready_s;
    logic          accept_s;

    // First set bit of cand at or after last+1, wrapping round; returns 0 when
    // cand is empty (callers qualify with |cand).
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] cand,
                                               input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last) + off) % N;
            if (!found && cand[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign cand_s     = s_axis_tvalid & src_enable;
    assign any_cand_s = |cand_s;
    assign pick_s     = rr_pick(cand_s, last_grant_r);

    assign sel_valid_s = s_axis_tvalid[grant_r];
    assign sel_data_s  = s_axis_tdata[int'(grant_r)*W +: W];
    assign sel_strb_s  = s_axis_tstrb[int'(grant_r)*SW +: SW];
    assign sel_last_s  = s_axis_tlast[grant_r];

    // A beat from the granted source is taken when it is valid and the sink can take it.
    assign accept_s = (state_r == ST_XFER) && sel_valid_s && sink_ready_s;

    assign grant_id = grant_r;
    assign busy     = (state_r == ST_XFER);

    // Arbitration FSM: pick a source in IDLE, hold it until its tlast beat is accepted.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(N - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_cand_s) begin
                        grant_r <= pick_s;
                        state_r <= ST_XFER;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (accept_s && sel_last_s) begin
                        last_grant_r <= grant_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the granted source sees ready, and only during a transfer.
    always_comb begin
        s_axis_tready = '0;
        if (state_r == ST_XFER) begin
            s_axis_tready[grant_r] = sink_ready_s;
        end else begin
            s_axis_tready = '0;
        end
    end

`ifdef AXI4S_ARB_OUTREG_EN

    logic [W-1:0]  buf_data_r [2];
    logic [SW-1:0] buf_strb_r [2];
    logic [1:0]    buf_last_r;
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [1:0]    count_r;
    logic          pop_s;

    // Ready depends only on buffer occupancy, never on the downstream ready.
    assign sink_ready_s = (count_r != 2'd2);
    assign pop_s        = (count_r != 2'd0) && m00_axis_tready;

    assign m00_axis_tvalid = (count_r != 2'd0);
    assign m00_axis_tdata  = buf_data_r[rd_ptr_r];
    assign m00_axis_tstrb  = buf_strb_r[rd_ptr_r];
    assign m00_axis_tlast  = buf_last_r[rd_ptr_r];

    // Two-entry skid buffer: write accepted beats, read at the downstream handshake.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            buf_data_r[0] <= '0;
            buf_data_r[1] <= '0;
            buf_strb_r[0] <= '0;
            buf_strb_r[1] <= '0;
            buf_last_r    <= 2'b00;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (accept_s) begin
                buf_data_r[wr_ptr_r] <= sel_data_s;
                buf_strb_r[wr_ptr_r] <= sel_strb_s;
                buf_last_r[wr_ptr_r] <= sel_last_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

`else

    assign sink_ready_s = m00_axis_tready;

    // Zero-latency path: the granted source drives the master port during XFER only.
    always_comb begin
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tstrb  = '0;
        m00_axis_tlast  = 1'b0;
        if (state_r == ST_XFER) begin
            m00_axis_tvalid = sel_valid_s;
            m00_axis_tdata  = sel_data_s;
            m00_axis_tstrb  = sel_strb_s;
            m00_axis_tlast  = sel_last_s;
        end else begin
            m00_axis_tvalid = 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi4s_rr_arbiter
// Randomised bench for axi4s_rr_arbiter. Each source plays numbered packets
// whose beat contents are a function of (source, packet, beat). A reference
// model decides grants from the round-robin rule and queues whole expected
// packets; a monitor pops that queue at every master-side handshake.
// Works with and without AXI4S_ARB_OUTREG_EN.
// ----------------------------------------------------------------------------
module tb_axi4s_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int SW = 8;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_tvalid = '0;
    logic [N*W-1:0]    s_tdata = '0;
    logic [N*SW-1:0]   s_tstrb = '0;
    logic [N-1:0]      s_tlast = '0;
    logic [N-1:0]      s_tready;
    logic [N-1:0]      src_enable = '0;
    logic              m_tvalid;
    logic [W-1:0]      m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [GW-1:0]     grant_id;
    logic              busy;

    always #5 clk = ~clk;

    axi4s_rr_arbiter #(.C_NUM_SRC(N), .C_AXIS_TDATA_WIDTH(W)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tdata     (s_tdata),
        .s_axis_tstrb     (s_tstrb),
        .s_axis_tlast     (s_tlast),
        .s_axis_tready    (s_tready),
        .src_enable       (src_enable),
        .m00_axis_tvalid  (m_tvalid),
        .m00_axis_tdata   (m_tdata),
        .m00_axis_tstrb   (m_tstrb),
        .m00_axis_tlast   (m_tlast),
        .m00_axis_tready  (m_tready),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] bdata(input int src, input int pkt, input int beat);
        logic [31:0] h;
        h = 32'(src * 7919 + pkt * 104729 + beat * 31337) ^ 32'hA5A5_5A5A;
        return {8'(src), 8'(beat), 16'(pkt), h};
    endfunction

    function automatic logic [7:0] bstrb(input int src, input int pkt, input int beat);
        logic [31:0] h;
        h = 32'(src * 13 + pkt * 7 + beat * 3);
        return h[7:0] ^ 8'h5A;
    endfunction

    // source drivers
    int  cur_len [N];
    int  cur_beat[N];
    int  cur_pkt [N];
    logic [N-1:0] hs_v = '0;
    bit  gapless = 1'b0;
    bit  quiesce = 1'b0;
    int  fixed_len = 0;
    int  tready_mode = 0;

    // reference model
    typedef struct { logic [63:0] d; logic [7:0] s; logic l; } beat_t;
    beat_t exp_q[$];
    bit    m_xfer = 1'b0;
    int    m_grant = 0;
    int    m_last = N - 1;
    int    m_rem = 0;
    bit    prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic  prev_l;

    task automatic new_pkt(input int i);
        cur_pkt[i]++;
        cur_beat[i] = 0;
        cur_len[i]  = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 8));
    endtask

    // stimulus: drive sources and downstream ready just after each rising edge
    initial begin
        for (int i = 0; i < N; i++) begin
            cur_pkt[i] = 0;
            new_pkt(i);
        end
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int i = 0; i < N; i++) new_pkt(i);
                s_tvalid = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (hs_v[i]) begin
                        cur_beat[i]++;
                        if (cur_beat[i] == cur_len[i]) new_pkt(i);
                    end
                    if (hs_v[i] || !s_tvalid[i] ||
                        (quiesce && cur_beat[i] == 0 && !(m_xfer && m_grant == i))) begin
                        if (quiesce && cur_beat[i] == 0 && !(m_xfer && m_grant == i))
                            s_tvalid[i] = 1'b0;
                        else if (gapless)
                            s_tvalid[i] = 1'b1;
                        else
                            s_tvalid[i] = ($urandom_range(0, 3) != 0);
                    end
                    s_tdata[i*W +: W]   = bdata(i, cur_pkt[i], cur_beat[i]);
                    s_tstrb[i*SW +: SW] = bstrb(i, cur_pkt[i], cur_beat[i]);
                    s_tlast[i]          = (cur_beat[i] == cur_len[i] - 1);
                end
            end
            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // monitor + model: evaluated at the falling edge, when all inputs are settled
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_xfer = 1'b0;
                m_last = N - 1;
                exp_q.delete();
                prev_stall = 1'b0;
                hs_v = '0;
            end else begin
                hs_v = s_tvalid & s_tready;
                if (prev_stall) begin
                    chk("stall_valid", 64'(m_tvalid), 64'd1);
                    chk("stall_data", m_tdata, prev_d);
                    chk("stall_last", 64'(m_tlast), 64'(prev_l));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("out_data", m_tdata, e.d);
                        chk("out_strb", 64'(m_tstrb), 64'(e.s));
                        chk("out_last", 64'(m_tlast), 64'(e.l));
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_d = m_tdata;
                prev_l = m_tlast;

                if (!m_xfer) begin
                    logic [N-1:0] cand;
                    chk("idle_busy", 64'(busy), 64'd0);
                    chk("idle_tready", 64'(s_tready), 64'd0);
                    cand = s_tvalid & src_enable;
                    if (cand != '0) begin
                        int g;
                        g = -1;
                        for (int off = 1; off <= N; off++)
                            if (g < 0 && cand[(m_last + off) % N]) g = (m_last + off) % N;
                        m_grant = g;
                        for (int b = cur_beat[g]; b < cur_len[g]; b++) begin
                            beat_t e;
                            e.d = bdata(g, cur_pkt[g], b);
                            e.s = bstrb(g, cur_pkt[g], b);
                            e.l = (b == cur_len[g] - 1);
                            exp_q.push_back(e);
                        end
                        m_rem  = cur_len[g] - cur_beat[g];
                        m_xfer = 1'b1;
                    end
                end else begin
                    logic [N-1:0] onehot;
                    onehot = '0;
                    onehot[m_grant] = 1'b1;
                    chk("xfer_busy", 64'(busy), 64'd1);
                    chk("grant_id", 64'(grant_id), 64'(m_grant));
                    chk("other_tready", 64'(s_tready & ~onehot), 64'd0);
`ifndef AXI4S_ARB_OUTREG_EN
                    chk("grant_tready", 64'(s_tready[m_grant]), 64'(m_tready));
`endif
                    if (hs_v[m_grant]) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_xfer = 1'b0;
                            m_last = m_grant;
                        end
                    end
                end
            end
        end
    end

    // phase sequencing
    initial begin
        #2;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_tstrb", 64'(m_tstrb), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // source 0 alone, 4-beat packets, ready held high
        src_enable = 4'b0001; fixed_len = 4; tready_mode = 0;
        repeat (60) @(posedge clk);
        // all sources always valid, 2-beat packets
        @(posedge clk); #1;
        src_enable = 4'b1111; gapless = 1'b1; fixed_len = 2;
        repeat (60) @(posedge clk);
        // source 2 valid but disabled; toggling downstream ready
        #1;
        src_enable = 4'b1011; gapless = 1'b0; fixed_len = 0; tready_mode = 1;
        repeat (200) @(posedge clk);
        // random enables changing every cycle, random ready
        tready_mode = 2;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            src_enable = 4'($urandom_range(0, 15));
        end
        // reset in the middle of a packet
        src_enable = 4'b1111; gapless = 1'b1; fixed_len = 5; tready_mode = 0;
        for (int k = 0; k < 100 && !busy; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tready", 64'(s_tready), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 50 && !busy; k++) @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd1);
        chk("post_rst_grant", 64'(grant_id), 64'd0);
        fixed_len = 0; gapless = 1'b0; tready_mode = 2;
        repeat (200) @(posedge clk);
        // drain
        quiesce = 1'b1; tready_mode = 0;
        for (int k = 0; k < 3000 && (exp_q.size() != 0 || busy); k++) @(posedge clk);
        repeat (4) @(posedge clk);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
